agenda_move_asteroides: RTL and testbench

Periodic initiator for asteroid movement. It generates a game tick every PERIODO_TICK clock cycles and, on each tick, requests one movement pass from the asteroid-movement control unit via movimenta_aste. It then waits for movimentacao_concluida_aste before the next request. It sits between the top-level game control unit and the asteroid-movement control unit, and reports overruns and timeouts for debug.

---
 rtl/agenda_move_asteroides.sv | 160 ++++++++++++++++
 tb/tb_agenda_move_asteroides.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/agenda_move_asteroides.sv
// Periodic scheduler for asteroid movement: issues one movement request per game tick and queues at most one late tick.
// Optional watchdog in AGUARDA is enabled by defining AGENDA_TIMEOUT_EN.
module agenda_move_asteroides #(
    parameter int PERIODO_TICK = 1000,
    parameter int TIMEOUT      = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       movimentacao_concluida_aste,
    output logic       movimenta_aste,
    output logic       tick,
    output logic       overrun,
    output logic       erro_timeout,
    output logic [7:0] contagem_passos,
    output logic [3:0] contagem_overrun,
    output logic [4:0] db_estado_agenda
);

    localparam int CNT_W = $clog2(PERIODO_TICK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIODO_TICK - 1);

    localparam logic [4:0] INICIAL     = 5'b00000;
    localparam logic [4:0] ESPERA_TICK = 5'b00001;
    localparam logic [4:0] SOLICITA    = 5'b00010;
    localparam logic [4:0] AGUARDA     = 5'b00011;
    localparam logic [4:0] CONCLUIDO   = 5'b00100;
    localparam logic [4:0] ERRO        = 5'b11111;

    logic [4:0]       estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pendente_q, pendente_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       passos_q, passos_d;
    logic [3:0]       cont_ov_q, cont_ov_d;
    logic             tick_w;
    logic             timeout_w;
    logic             limpa_w;

    assign tick_w  = (cnt_q == CNT_MAX);
    // Flags are only cleared once the FSM has come to rest with the game stopped.
    assign limpa_w = (estado_q == INICIAL) && !habilita;

`ifdef AGENDA_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q;
    logic            erro_q;

    assign timeout_w = (estado_q == AGUARDA) && (wd_q == WD_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q   <= '0;
            erro_q <= 1'b0;
        end else begin
            wd_q <= (estado_q == AGUARDA) ? wd_q + WD_W'(1) : '0;
            if (limpa_w)
                erro_q <= 1'b0;
            else if (timeout_w && !movimentacao_concluida_aste)
                erro_q <= 1'b1;
        end
    end

    assign erro_timeout = erro_q;
`else
    assign timeout_w    = 1'b0;
    assign erro_timeout = 1'b0;
`endif

    always_comb begin
        cnt_d      = '0;
        estado_d   = estado_q;
        pendente_d = pendente_q;
        overrun_d  = overrun_q;
        passos_d   = passos_q;
        cont_ov_d  = cont_ov_q;

        if (habilita)
            cnt_d = tick_w ? '0 : cnt_q + CNT_W'(1);

        case (estado_q)
            INICIAL: begin
                if (habilita)
                    estado_d = ESPERA_TICK;
            end
            ESPERA_TICK: begin
                if (!habilita) begin
                    estado_d = INICIAL;
                end else if (tick_w || pendente_q) begin
                    estado_d   = SOLICITA;
                    pendente_d = 1'b0;
                end
            end
            SOLICITA: begin
                estado_d = habilita ? AGUARDA : INICIAL;
            end
            // Never abandon a pass in progress, even when the game is stopped.
            AGUARDA: begin
                if (movimentacao_concluida_aste)
                    estado_d = CONCLUIDO;
                else if (timeout_w)
                    estado_d = ERRO;
            end
            CONCLUIDO: begin
                passos_d = passos_q + 8'd1;
                estado_d = habilita ? ESPERA_TICK : INICIAL;
            end
            ERRO: begin
                if (!habilita)
                    estado_d = INICIAL;
            end
            default: estado_d = INICIAL;
        endcase

        // A tick that cannot be served now is queued once; any further one is lost.
        if (tick_w && (estado_q != ESPERA_TICK)) begin
            if (!pendente_q) begin
                pendente_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
                if (cont_ov_q != 4'hF)
                    cont_ov_d = cont_ov_q + 4'd1;
            end
        end

        if (limpa_w) begin
            pendente_d = 1'b0;
            overrun_d  = 1'b0;
            cont_ov_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            cnt_q      <= '0;
            pendente_q <= 1'b0;
            overrun_q  <= 1'b0;
            passos_q   <= '0;
            cont_ov_q  <= '0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            pendente_q <= pendente_d;
            overrun_q  <= overrun_d;
            passos_q   <= passos_d;
            cont_ov_q  <= cont_ov_d;
        end
    end

    assign movimenta_aste   = (estado_q == SOLICITA);
    assign tick             = tick_w;
    assign overrun          = overrun_q;
    assign contagem_passos  = passos_q;
    assign contagem_overrun = cont_ov_q;
    assign db_estado_agenda = estado_q;

endmodule

// File: tb/tb_agenda_move_asteroides.sv
// Scoreboard bench for agenda_move_asteroides with PERIODO_TICK=8, TIMEOUT=6.
// Request pulses are checked against a queue of expected cycle numbers; state and flags are checked directly.
module tb_agenda_move_asteroides;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       habilita = 1'b0;
    logic       done = 1'b0;
    logic       movimenta_aste;
    logic       tick;
    logic       overrun;
    logic       erro_timeout;
    logic [7:0] contagem_passos;
    logic [3:0] contagem_overrun;
    logic [4:0] db_estado_agenda;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_q[$];
    bit resp_en  = 1'b0;
    int resp_delay = 1;

    agenda_move_asteroides #(
        .PERIODO_TICK(8),
        .TIMEOUT(6)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .habilita(habilita),
        .movimentacao_concluida_aste(done),
        .movimenta_aste(movimenta_aste),
        .tick(tick),
        .overrun(overrun),
        .erro_timeout(erro_timeout),
        .contagem_passos(contagem_passos),
        .contagem_overrun(contagem_overrun),
        .db_estado_agenda(db_estado_agenda)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {11'd0, db_estado_agenda, movimenta_aste, tick, overrun, erro_timeout,
                contagem_passos, contagem_overrun};
    endfunction

    // Monitor: every request pulse must match the next queued expected cycle.
    always @(negedge clk) begin
        if (movimenta_aste === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: pulse at cycle %0d, expected none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    n_err++;
                    $display("FAIL pulse_cycle: pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    // Movement-unit model: one-cycle done, resp_delay edges after seeing the request.
    always begin
        @(negedge clk);
        if (rst_n && resp_en && movimenta_aste) begin
            repeat (resp_delay) @(posedge clk);
            #1 done = 1'b1;
            @(posedge clk);
            #1 done = 1'b0;
        end
    end

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        habilita = 1'b0;
        resp_en  = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_en(output int h);
        @(negedge clk);
        h = cyc;
        habilita = 1'b1;
    endtask

    initial begin
        int h;

        // Reset held, then released with the game stopped
        repeat (3) @(negedge clk);
        chk("reset_held_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", all_outs(), 32'd0);
        end

        // Regular passes with done two cycles after each request
        do_reset();
        resp_en = 1'b1;
        resp_delay = 2;
        start_en(h);
        exp_q.push_back(h + 8);
        exp_q.push_back(h + 16);
        exp_q.push_back(h + 24);
        at_cyc(h + 7);
        chk("tick_high", {31'd0, tick}, 32'd1);
        at_cyc(h + 8);
        chk("tick_low_after", {31'd0, tick}, 32'd0);
        at_cyc(h + 12);
        chk("passos_after_1", {24'd0, contagem_passos}, 32'd1);
        chk("state_espera", {27'd0, db_estado_agenda}, 32'h01);
        at_cyc(h + 30);
        chk("passos_after_3", {24'd0, contagem_passos}, 32'd3);
        chk("overrun_regular", {31'd0, overrun}, 32'd0);
        chk("queue_drained_regular", exp_q.size(), 32'd0);

`ifndef AGENDA_TIMEOUT_EN
        // Late movement unit: one tick queued, then one lost
        do_reset();
        resp_en = 1'b1;
        resp_delay = 12;
        start_en(h);
        exp_q.push_back(h + 8);
        exp_q.push_back(h + 23);
        exp_q.push_back(h + 38);
        at_cyc(h + 20);
        chk("late_state_aguarda", {27'd0, db_estado_agenda}, 32'h03);
        at_cyc(h + 22);
        chk("late_passos_1", {24'd0, contagem_passos}, 32'd1);
        at_cyc(h + 31);
        chk("late_overrun_before", {31'd0, overrun}, 32'd0);
        at_cyc(h + 32);
        chk("late_overrun_set", {31'd0, overrun}, 32'd1);
        chk("late_cont_overrun", {28'd0, contagem_overrun}, 32'd1);
        at_cyc(h + 37);
        chk("late_passos_2", {24'd0, contagem_passos}, 32'd2);
        chk("late_state_espera", {27'd0, db_estado_agenda}, 32'h01);
        at_cyc(h + 39);
        chk("queue_drained_late", exp_q.size(), 32'd0);

        // No done at all: waits indefinitely, lost ticks saturate at 15
        do_reset();
        start_en(h);
        exp_q.push_back(h + 8);
        at_cyc(h + 15);
        chk("nodone_state", {27'd0, db_estado_agenda}, 32'h03);
        at_cyc(h + 25);
        chk("nodone_cont_1", {28'd0, contagem_overrun}, 32'd1);
        at_cyc(h + 135);
        chk("nodone_cont_14", {28'd0, contagem_overrun}, 32'd14);
        at_cyc(h + 150);
        chk("nodone_cont_sat", {28'd0, contagem_overrun}, 32'd15);
        chk("nodone_still_aguarda", {27'd0, db_estado_agenda}, 32'h03);
        chk("nodone_no_erro", {31'd0, erro_timeout}, 32'd0);
        chk("queue_drained_nodone", exp_q.size(), 32'd0);
`else
        // Watchdog expires, then stopping the game clears the error
        do_reset();
        start_en(h);
        exp_q.push_back(h + 8);
        at_cyc(h + 14);
        chk("wd_state_aguarda", {27'd0, db_estado_agenda}, 32'h03);
        chk("wd_erro_before", {31'd0, erro_timeout}, 32'd0);
        at_cyc(h + 15);
        chk("wd_state_erro", {27'd0, db_estado_agenda}, 32'h1F);
        chk("wd_erro_set", {31'd0, erro_timeout}, 32'd1);
        at_cyc(h + 16);
        habilita = 1'b0;
        at_cyc(h + 17);
        chk("wd_state_inicial", {27'd0, db_estado_agenda}, 32'h00);
        at_cyc(h + 18);
        chk("wd_erro_cleared", {31'd0, erro_timeout}, 32'd0);
        chk("wd_overrun_cleared", {31'd0, overrun}, 32'd0);
        chk("queue_drained_wd", exp_q.size(), 32'd0);
`endif

        // Game stopped mid-pass: finish the pass, then go idle
        do_reset();
        resp_en = 1'b1;
        resp_delay = 6;
        start_en(h);
        exp_q.push_back(h + 8);
        at_cyc(h + 10);
        habilita = 1'b0;
        at_cyc(h + 13);
        chk("stop_still_aguarda", {27'd0, db_estado_agenda}, 32'h03);
        at_cyc(h + 15);
        chk("stop_concluido", {27'd0, db_estado_agenda}, 32'h04);
        at_cyc(h + 16);
        chk("stop_inicial", {27'd0, db_estado_agenda}, 32'h00);
        chk("stop_passos", {24'd0, contagem_passos}, 32'd1);
        at_cyc(h + 20);
        chk("stop_stays_inicial", {27'd0, db_estado_agenda}, 32'h00);
        chk("queue_drained_stop", exp_q.size(), 32'd0);

        // Asynchronous reset asserted while waiting for done
        do_reset();
        start_en(h);
        exp_q.push_back(h + 8);
        at_cyc(h + 12);
        chk("areset_pre_aguarda", {27'd0, db_estado_agenda}, 32'h03);
        #2 rst_n = 1'b0;
        #1 chk("areset_immediate", all_outs(), 32'd0);
        chk("queue_drained_areset", exp_q.size(), 32'd0);
        habilita = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("areset_after_release", all_outs(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
